// File: rtl/core_mem_seq_pkg.sv
// core_mem_seq_pkg: shared state encoding and constants for the core memory sequencer.
package core_mem_seq_pkg;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/ext_burst_limiter.sv
// ext_burst_limiter: counts consecutive external grants and blocks more once the burst cap is reached.
module ext_burst_limiter #(
  parameter int EXT_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic allow
);
  localparam int CW = $clog2(EXT_BURST_MAX + 1);
  logic [CW-1:0] burst_cnt;
  assign allow = burst_cnt < CW'(EXT_BURST_MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) burst_cnt <= '0;
    else if (clr) burst_cnt <= '0;
    else if (inc) burst_cnt <= burst_cnt + CW'(1);
endmodule

// File: rtl/core_mem_sequencer.sv
// core_mem_sequencer: shares one single-port SRAM between instruction fetch, core load/store
// and an external requester, and stalls the core through core_en.
module core_mem_sequencer
  import core_mem_seq_pkg::*;
#(
  parameter int MEM_AW        = 10,
  parameter int EXT_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       core_pc,
  input  logic [31:0]       core_alu_res,
  input  logic [31:0]       core_wdata,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  output logic [31:0]       core_instr,
  output logic [31:0]       core_rdata,
  output logic              core_en,
  output logic              sram_en,
  output logic              sram_we,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [MEM_AW-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata
);
  state_t state, state_nx;
  logic [31:0] instr_q;
  logic ext_rd_pend, ext_ok;
  logic [MEM_AW-1:0] pc_w, data_w;
  logic unused_addr_bits;
  assign pc_w = core_pc[MEM_AW+1:2];
  assign data_w = core_alu_res[MEM_AW+1:2];
  assign unused_addr_bits = ^{core_pc[31:MEM_AW+2], core_pc[1:0], core_alu_res[31:MEM_AW+2], core_alu_res[1:0]};
  ext_burst_limiter #(.EXT_BURST_MAX(EXT_BURST_MAX)) u_limiter (
    .clk  (clk),
    .rst  (rst),
    .inc  (ext_gnt),
    .clr  (core_en),
    .allow(ext_ok)
  );
  assign core_instr = (state == S_EXEC) ? sram_rdata : instr_q;
  assign core_rdata = (state == S_LOAD) ? sram_rdata : 32'h0;
  assign ext_rvalid = ext_rd_pend;
  assign ext_rdata = sram_rdata;
  always_comb begin
    state_nx = state;
    sram_en = 1'b0;
    sram_we = 1'b0;
    sram_addr = pc_w;
    sram_wdata = core_wdata;
    ext_gnt = 1'b0;
    core_en = 1'b0;
    case (state)
      S_FETCH: begin
        sram_en = 1'b1;
        if (ext_req && ext_ok) begin
          ext_gnt = 1'b1;
          sram_we = ext_we;
          sram_addr = ext_addr;
          sram_wdata = ext_wdata;
        end else state_nx = S_EXEC;
      end
      S_EXEC: begin
        sram_addr = data_w;
        sram_en = core_mem_write || core_mem_read;
        sram_we = core_mem_write;
        core_en = !(core_mem_read && !core_mem_write);
        state_nx = core_en ? S_FETCH : S_LOAD;
      end
      default: begin
        core_en = 1'b1;
        state_nx = S_FETCH;
      end
    endcase
    // Outputs stay quiet for the whole reset window so an interrupted store never lands.
    if (!rst) begin
      sram_en = 1'b0;
      sram_we = 1'b0;
      ext_gnt = 1'b0;
      core_en = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_FETCH;
      instr_q <= NOP_INSTR;
      ext_rd_pend <= 1'b0;
    end else begin
      state <= state_nx;
      ext_rd_pend <= ext_gnt && !ext_we;
      if (state == S_EXEC) instr_q <= sram_rdata;
    end
endmodule

// File: tb/tb_core_mem_sequencer.sv
// tb_core_mem_sequencer: drives the sequencer as a core plus external requester against a
// behavioural SRAM, predicting every instruction and external transaction from a memory image.
module tb_core_mem_sequencer;
  localparam int AW = 10;
  localparam int BMAX = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] core_pc = '0, core_alu_res = '0, core_wdata = '0;
  logic core_mem_read = 1'b0, core_mem_write = 1'b0;
  logic [31:0] core_instr, core_rdata, sram_wdata, ext_rdata;
  logic [31:0] sram_rdata = '0;
  logic core_en, sram_en, sram_we, ext_gnt, ext_rvalid;
  logic [AW-1:0] sram_addr;
  logic ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [31:0] ext_wdata = '0;

  core_mem_sequencer #(.MEM_AW(AW), .EXT_BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .core_pc(core_pc), .core_alu_res(core_alu_res), .core_wdata(core_wdata),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_instr(core_instr), .core_rdata(core_rdata), .core_en(core_en),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  always @(posedge clk)
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [31:0] wdata;} ext_op_t;
  ext_op_t ext_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_instr, exp_data;
  logic exp_pend;
  int errors = 0, checks = 0;

  task automatic drive_ext();
    if (ext_q.size() > 0) begin
      ext_req = 1'b1;
      ext_we = ext_q[0].we;
      ext_addr = ext_q[0].addr;
      ext_wdata = ext_q[0].wdata;
    end else begin
      ext_req = 1'b0;
      ext_we = 1'($urandom);
      ext_addr = AW'($urandom);
      ext_wdata = $urandom;
    end
  endtask

  // kind: 0 = ALU/branch, 1 = load, 2 = store
  task automatic do_instr(input int kind, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd);
    int grants = 0;
    logic [AW-1:0] pw = pc[AW+1:2];
    logic [AW-1:0] dw = alu[AW+1:2];
    logic [31:0] instr;
    core_pc = pc;
    core_alu_res = alu;
    core_wdata = wd;
    core_mem_read = 1'($urandom);
    core_mem_write = 1'($urandom);
    forever begin
      drive_ext();
      #1;
      checks++;
      if (ext_rvalid !== exp_pend || (exp_pend && ext_rdata !== exp_data)) begin
        errors++;
        $display("FAIL ext_rvalid got=%b/%h want=%b/%h", ext_rvalid, ext_rdata, exp_pend, exp_data);
      end
      if (ext_q.size() == 0 || grants >= BMAX) break;
      checks++;
      if (ext_gnt !== 1'b1 || sram_en !== 1'b1 || sram_we !== ext_q[0].we || sram_addr !== ext_q[0].addr || core_en !== 1'b0) begin
        errors++;
        $display("FAIL ext_grant got gnt=%b en=%b we=%b addr=%h core_en=%b want gnt=1 en=1 we=%b addr=%h core_en=0",
                 ext_gnt, sram_en, sram_we, sram_addr, core_en, ext_q[0].we, ext_q[0].addr);
      end
      exp_pend = !ext_q[0].we;
      exp_data = ref_mem[ext_q[0].addr];
      if (ext_q[0].we) ref_mem[ext_q[0].addr] = ext_q[0].wdata;
      void'(ext_q.pop_front());
      grants++;
      @(negedge clk);
    end
    checks++;
    if (ext_gnt !== 1'b0 || sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== pw || core_en !== 1'b0 ||
        core_instr !== last_instr || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch got gnt=%b en=%b we=%b addr=%h core_en=%b instr=%h rdata=%h want 0 1 0 %h 0 %h 0",
               ext_gnt, sram_en, sram_we, sram_addr, core_en, core_instr, core_rdata, pw, last_instr);
    end
    exp_pend = 1'b0;
    @(negedge clk);
    core_mem_read = (kind == 1);
    core_mem_write = (kind == 2);
    drive_ext();
    #1;
    instr = ref_mem[pw];
    checks++;
    if (core_instr !== instr || ext_gnt !== 1'b0 || ext_rvalid !== 1'b0 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL exec_common got instr=%h gnt=%b rvalid=%b rdata=%h want instr=%h gnt=0 rvalid=0 rdata=0",
               core_instr, ext_gnt, ext_rvalid, core_rdata, instr);
    end
    checks++;
    if (kind == 2) begin
      if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== dw || sram_wdata !== wd || core_en !== 1'b1) begin
        errors++;
        $display("FAIL exec_store got en=%b we=%b addr=%h wdata=%h core_en=%b want 1 1 %h %h 1",
                 sram_en, sram_we, sram_addr, sram_wdata, core_en, dw, wd);
      end
      ref_mem[dw] = wd;
    end else if (kind == 1) begin
      if (sram_en !== 1'b1 || sram_we !== 1'b0 || sram_addr !== dw || core_en !== 1'b0) begin
        errors++;
        $display("FAIL exec_load got en=%b we=%b addr=%h core_en=%b want 1 0 %h 0", sram_en, sram_we, sram_addr, core_en, dw);
      end
    end else if (sram_en !== 1'b0 || core_en !== 1'b1) begin
      errors++;
      $display("FAIL exec_alu got en=%b core_en=%b want 0 1", sram_en, core_en);
    end
    last_instr = instr;
    @(negedge clk);
    if (kind == 1) begin
      drive_ext();
      #1;
      checks++;
      if (core_en !== 1'b1 || sram_en !== 1'b0 || ext_gnt !== 1'b0 || core_rdata !== ref_mem[dw] || core_instr !== instr) begin
        errors++;
        $display("FAIL load_wb got core_en=%b en=%b gnt=%b rdata=%h instr=%h want 1 0 0 %h %h",
                 core_en, sram_en, ext_gnt, core_rdata, core_instr, ref_mem[dw], instr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ext_q.push_back('{we: 1'b1, addr: 10'h3, wdata: 32'h1234_5678});
    drive_ext();
    core_mem_write = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sram_en !== 1'b0 || core_en !== 1'b0 || ext_gnt !== 1'b0 || ext_rvalid !== 1'b0 || core_instr !== NOP) begin
      errors++;
      $display("FAIL reset got en=%b core_en=%b gnt=%b rvalid=%b instr=%h want 0 0 0 0 %h",
               sram_en, core_en, ext_gnt, ext_rvalid, core_instr, NOP);
    end
    void'(ext_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    last_instr = NOP;
    exp_pend = 1'b0;
  endtask

  task automatic test_alu();
    mem[0] <= 32'h0050_0093;
    ref_mem[0] = 32'h0050_0093;
    do_instr(0, 32'h0, 32'h0, 32'h0);
    do_instr(0, 32'h4, 32'h0, 32'h0);
  endtask

  task automatic test_load();
    do_instr(1, 32'h4, 32'h100, 32'h0);
  endtask

  task automatic test_store();
    do_instr(2, 32'h8, 32'h200, 32'hDEAD_BEEF);
    ext_q.push_back('{we: 1'b0, addr: 10'h080, wdata: 32'h0});
    do_instr(0, 32'hC, 32'h0, 32'h0);
  endtask

  task automatic test_ext_burst();
    for (int a = 5; a <= 9; a++) ext_q.push_back('{we: 1'b0, addr: AW'(a), wdata: 32'h0});
    do_instr(0, 32'h10, 32'h0, 32'h0);
    do_instr(1, 32'h14, 32'h24, 32'h0);
  endtask

  task automatic test_reset_mid_store();
    logic [AW-1:0] dw = 10'h0A0;
    core_pc = 32'h40;
    core_mem_write = 1'b0;
    core_mem_read = 1'b0;
    drive_ext();
    @(negedge clk);
    core_alu_res = 32'h280;
    core_wdata = 32'hCAFE_F00D;
    core_mem_write = 1'b1;
    #1;
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== dw) begin
      errors++;
      $display("FAIL store_armed got we=%b addr=%h want 1 %h", sram_we, sram_addr, dw);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sram_en !== 1'b0 || sram_we !== 1'b0 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got en=%b we=%b core_en=%b want 0 0 0", sram_en, sram_we, core_en);
    end
    @(negedge clk);
    rst = 1'b1;
    last_instr = NOP;
    exp_pend = 1'b0;
    ext_q.push_back('{we: 1'b0, addr: dw, wdata: 32'h0});
    do_instr(0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc = $urandom, alu = $urandom;
      pc[AW+1:2] = AW'($urandom_range(0, 31));
      alu[AW+1:2] = AW'($urandom_range(0, 31));
      repeat ($urandom_range(0, 6))
        ext_q.push_back('{we: 1'($urandom), addr: AW'($urandom_range(0, 31)), wdata: $urandom});
      do_instr(int'($urandom_range(0, 2)), pc, alu, $urandom);
    end
    while (ext_q.size() > 0) do_instr(0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ext_burst();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
